// File: rtl/pdm_dac.sv
// pdm_dac: interpolating sigma-delta PDM DAC with valid/ready sample input.
// Define PDM_ORDER2_EN to replace the 1st-order modulator with a saturating 2nd-order one.
module pdm_dac #(
    parameter int RESOLUTION = 8,
    parameter int RATE_LOG2  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [RESOLUTION-1:0] sample,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  pdm,
    output logic                  underrun
);
    localparam int PW = (RATE_LOG2 > 0) ? RATE_LOG2 : 1;
    localparam int AW = RESOLUTION + RATE_LOG2;
    localparam int DW = RESOLUTION + 1;

    logic [PW-1:0]            phase;
    logic                     tick;
    logic                     full;
    logic                     accept;
    logic [RESOLUTION-1:0]    pending;
    logic [RESOLUTION-1:0]    target;
    logic [RESOLUTION-1:0]    x;
    logic signed [DW-1:0]     delta;
    logic signed [DW-1:0]     delta_nxt;
    logic [AW-1:0]            delta_ext;
    logic [AW-1:0]            acc;

    assign tick         = (RATE_LOG2 == 0) || (&phase);
    assign sample_ready = !full || tick;
    assign accept       = sample_valid && sample_ready;
    assign underrun     = tick && !full;

    // The new slope is applied on the tick edge itself, so acc lands on target<<RATE_LOG2 at the next tick.
    assign delta_nxt = tick ? (full ? $signed({1'b0, pending}) - $signed({1'b0, target}) : '0) : delta;
    assign delta_ext = AW'(delta_nxt);
    assign x         = acc[AW-1:RATE_LOG2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase   <= '0;
            full    <= 1'b0;
            pending <= '0;
            target  <= '0;
            delta   <= '0;
            acc     <= '0;
        end else begin
            phase   <= (RATE_LOG2 == 0) ? '0 : phase + 1'b1;
            full    <= accept || (full && !tick);
            pending <= accept ? sample : pending;
            target  <= (tick && full) ? pending : target;
            delta   <= delta_nxt;
            acc     <= acc + delta_ext;
        end
    end

`ifdef PDM_ORDER2_EN
    localparam int IW = RESOLUTION + 3;
    localparam logic signed [IW+1:0] LIM  = (IW+2)'(2 ** (RESOLUTION + 1));
    localparam logic signed [IW+1:0] NLIM = -LIM;
    localparam logic signed [IW+1:0] FS   = (IW+2)'(2 ** RESOLUTION);

    logic signed [IW-1:0] i1;
    logic signed [IW-1:0] i2;
    logic signed [IW-1:0] i1_nxt;
    logic signed [IW-1:0] i2_nxt;
    logic signed [IW+1:0] xs;
    logic signed [IW+1:0] fb;
    logic signed [IW+1:0] i1w;
    logic signed [IW+1:0] i2w;

    function automatic logic signed [IW-1:0] sat(input logic signed [IW+1:0] v);
        return (v > LIM) ? LIM[IW-1:0] : (v < NLIM) ? NLIM[IW-1:0] : v[IW-1:0];
    endfunction

    assign xs     = {{(IW+2-RESOLUTION){1'b0}}, x};
    assign fb     = pdm ? FS : '0;
    assign i1w    = i1 + xs - fb;
    assign i1_nxt = sat(i1w);
    assign i2w    = i2 + i1_nxt - fb;
    assign i2_nxt = sat(i2w);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i1  <= '0;
            i2  <= '0;
            pdm <= 1'b0;
        end else begin
            i1  <= i1_nxt;
            i2  <= i2_nxt;
            pdm <= !i2_nxt[IW-1];
        end
    end
`else
    logic [RESOLUTION-1:0] sigma;
    logic [RESOLUTION:0]   sum1;

    assign sum1 = {1'b0, sigma} + {1'b0, x};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sigma <= '0;
            pdm   <= 1'b0;
        end else begin
            sigma <= sum1[RESOLUTION-1:0];
            pdm   <= sum1[RESOLUTION];
        end
    end
`endif
endmodule

// File: doc/pdm_dac.md
# pdm_dac

Sigma-delta DAC transmitter: the output counterpart of the sigma-delta ADC front end. Accepts PCM samples over a valid/ready handshake at a fixed sample rate derived from the system clock. Linearly interpolates between consecutive samples and drives a 1-bit PDM pin for an external RC reconstruction filter. At 1st order, its PDM density matches what the ADC-side averager decodes (ones per 2^RESOLUTION clocks = sample value).

## Interface
- RESOLUTION, 8, PCM sample width (unsigned), 4..16.
- RATE_LOG2, 2, sample period = 2^RATE_LOG2 clocks (default matches the divide-by-4 filter strobe), 0..6.

- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- sample  in  RESOLUTION  unsigned PCM sample.
- sample_valid  in  1  sample present.
- sample_ready  out  1  block can take sample this cycle.
- pdm  out  RESOLUTION-independent 1  registered PDM output.
- underrun  out  1  one-cycle pulse: sample tick found no pending sample.

## Operation
- phase: RATE_LOG2-bit free-running counter from 0 after reset; tick = (phase == 2^RATE_LOG2-1). For RATE_LOG2=0, tick every cycle.
- Holding register pending + flag full. sample_ready = !full | tick (registered state only, no combinational path from sample_valid). Accept = sample_valid & sample_ready.
- On tick with full: target <= pending; delta <= pending - target (signed, RESOLUTION+1 bits); full <= 0, or stays 1 if accepting in the same cycle (new sample goes into pending).
- On tick with !full: delta <= 0, target unchanged, underrun pulses 1 for that cycle (a same-cycle accept fills pending, but the tick is still an underrun).
- Interpolator acc, RESOLUTION+RATE_LOG2 bits unsigned: acc <= acc + sign-extended delta every clock. Because of the delta/tick alignment, acc equals target<<RATE_LOG2 exactly at each tick; no overflow for legal inputs. x = acc >> RATE_LOG2.
- 1st-order modulator: sigma (RESOLUTION bits); {c, sigma} <= sigma + x; pdm <= c. Ones density = x / 2^RESOLUTION.

## Timing
- Reset values: pdm 0, underrun 0, sample_ready 1, full 0, pending/target/delta/acc/sigma/phase 0.
- Accepted sample reaches pending next edge. It is consumed at the next tick, and the ramp starts the cycle after tick. It finishes 2^RATE_LOG2 clocks later, and the first pdm bit influenced appears one cycle after x changes.
- Max throughput: one sample per 2^RATE_LOG2 clocks with one sample of buffering; a second accept blocks (ready low) until the next tick.
- reset_n assertion mid-ramp or mid-handshake: all state cleared immediately. Pending sample discarded, pdm 0 while asserted, phase restarts at 0 on release.

## Configuration
- PDM_ORDER2_EN defined: 2nd-order modulator replaces 1st. Signed integrators i1, i2, RESOLUTION+3 bits, reset 0; f = pdm ? 2^RESOLUTION : 0.
  - i1 <= sat(i1 + x - f)
  - i2 <= sat(i2 + i1_next - f)
  - pdm <= !i2_next[msb]
  - sat clamps to ±2^(RESOLUTION+1).
  - Long-run density still x / 2^RESOLUTION (±1 per 2^RESOLUTION window after settling), with noise shaped to higher frequencies.
- Not defined: 1st-order path only; i1/i2 not built.
- Handshake, interpolator, underrun identical in both builds.

## Test plan
- Reset (RESOLUTION=8, RATE_LOG2=2): assert reset_n low mid-stream -> pdm=0, underrun=0, sample_ready=1 immediately; after release, phase restarts and no stale sample is output.
- Constant 64 streamed every tick, 1st order -> after settling, exactly 64 ones in every 256-clock window. Value 0 -> pdm constant 0; value 255 -> 255 ones per 256 clocks.
- Step 0 -> 128 -> x takes 32, 64, 96, 128 on the four clocks after the consuming tick, then holds 128.
- Starvation: stop sample_valid -> underrun high exactly one cycle per missed tick, x holds last target, pdm density unchanged.
- Backpressure: sample_valid held high with back-to-back samples A, B -> A accepted, ready low until next tick. B is accepted in the tick cycle, A consumed the same cycle, and no sample is lost or duplicated.
- PDM_ORDER2_EN, constant 200 -> density 200/256 ±1 per 256-clock window, integrators never exceed saturation bounds.
